// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker.
//   state_t    : sweep FSM states (IDLE/HOLD/SAMPLE/DONE)
//   vec_count  : number of input vectors for an N_IN-input unit (2^N_IN)
//   XOR3, MAJ3 : reference truth tables for the 3-input exercises
//   CNT_W      : settle counter width (covers SETTLE up to 15)
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Bit i of a truth table is the expected Y for input vector i (A = MSB).
  localparam logic [7:0] XOR3 = 8'b1001_0110;
  localparam logic [7:0] MAJ3 = 8'b1110_1000;

  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// settle_timer: loadable down-counter for the per-vector settle window.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with SETTLE-1 (start of a vector window)
//   expire     : high once the counter has reached zero
// With SETTLE=1 the counter loads zero, so expire is high in the first
// hold cycle and each vector gets one hold cycle plus one sample cycle.
module settle_timer
  import checker_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector 0..2^N_IN-1 into a
// combinational unit under test, samples its response after a settle
// window and compares against the EXPECTED truth table.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : sweep request, honoured only in IDLE or DONE
//   vec_o            : vector driven to the UUT (MSB = input A)
//   y_i              : UUT response, assumed synchronous to clk
//   busy / done      : sweep in progress / results held
//   pass             : no mismatches in the last sweep (valid with done)
//   err_count        : mismatching vectors in the last sweep
//   first_fail_vec   : lowest-indexed mismatching vector
//   first_fail_valid : at least one mismatch recorded
// Optional build macro TRUTH_TABLE_CHECKER_LOG_EN adds resp_log, the raw
// response captured for each vector.
module truth_table_checker
  import checker_pkg::*;
#(
  parameter int unsigned               N_IN     = 3,
  parameter logic [(2**N_IN)-1:0]      EXPECTED = 8'b1001_0110,
  parameter int unsigned               SETTLE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_o,
  input  logic              y_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
  ,
  output logic [(2**N_IN)-1:0] resp_log
`endif
);

  localparam int unsigned     VEC_CNT  = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(VEC_CNT - 1);
  localparam logic [N_IN:0]   ERR_SAT  = (N_IN + 1)'(VEC_CNT);

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic            accept;
  logic            timer_load;
  logic            expire;
  logic            last_vec;
  logic            mismatch;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .expire (expire)
  );

  assign last_vec = (idx == LAST_IDX);
  assign mismatch = (state == SAMPLE) && (y_i != EXPECTED[idx]);
  // The window restarts on an accepted start and whenever a new vector
  // is stepped in after a sample.
  assign timer_load = accept || ((state == SAMPLE) && !last_vec);
  assign vec_o = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HOLD;
          accept    = 1'b1;
        end
      end
      HOLD:    if (expire) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (accept) begin
      idx              <= '0;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == SAMPLE) begin
      if (mismatch && (err_count != ERR_SAT)) begin
        err_count <= err_count + 1'b1;
      end
      if (mismatch && !first_fail_valid) begin
        first_fail_vec   <= idx;
        first_fail_valid <= 1'b1;
      end
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        // Fold in the final vector's result, not yet visible in err_count.
        pass <= (err_count == '0) && !mismatch;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef TRUTH_TABLE_CHECKER_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_log <= '0;
    end else if (accept) begin
      resp_log <= '0;
    end else if (state == SAMPLE) begin
      resp_log[idx] <= y_i;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Testbench for truth_table_checker. Instance A uses the default build
// (N_IN=3, XOR3, SETTLE=1) with a table-driven UUT; instance B uses
// SETTLE=3 with MAJ3 and a majority-gate UUT.
module tb_truth_table_checker;

  localparam logic [7:0] EXP_A = 8'b1001_0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] tbl_a   = 8'h00;

  logic [2:0] vec_a, vec_b, ffv_a, ffv_b;
  logic       y_a, y_b;
  logic       busy_a, done_a, pass_a, ffval_a;
  logic       busy_b, done_b, pass_b, ffval_b;
  logic [3:0] err_a, err_b;
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
  logic [7:0] log_a, log_b;
`endif

  // UUT A responds from a programmable table; UUT B is a majority gate.
  assign y_a = tbl_a[vec_a];
  assign y_b = (vec_b[2] & vec_b[1]) | (vec_b[2] & vec_b[0]) | (vec_b[1] & vec_b[0]);

  truth_table_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_o(vec_a), .y_i(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a)
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
    , .resp_log(log_a)
`endif
  );

  truth_table_checker #(.N_IN(3), .EXPECTED(checker_pkg::MAJ3), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_o(vec_b), .y_i(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b)
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
    , .resp_log(log_b)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int k_cur = 0;

  typedef struct {
    int         err;
    int         ffv;
    bit         ffval;
    bit         pass;
    int         dcyc;
    logic [7:0] log;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: errors are the differing bits between response and expected
  // table, first failure is the lowest differing bit, done lands 8 windows
  // of 2 cycles after acceptance.
  function automatic exp_t model(input logic [7:0] resp, input int k);
    exp_t e;
    logic [7:0] diff;
    diff    = resp ^ EXP_A;
    e.err   = $countones(diff);
    e.ffval = (diff != 8'h00);
    e.ffv   = 0;
    for (int v = 7; v >= 0; v--) if (diff[v]) e.ffv = v;
    e.pass  = (e.err == 0);
    e.dcyc  = k + 8 * 2;
    e.log   = resp;
    return e;
  endfunction

  // Monitor: checks vector stepping while busy and pops the scoreboard on
  // each rising done.
  initial begin
    bit   dq;
    exp_t e;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_a) check("vec_step", int'(vec_a), (cyc - k_cur) / 2);
      if (done_a && !dq) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.dcyc);
          check("err_count", int'(err_a), e.err);
          check("first_fail_valid", int'(ffval_a), int'(e.ffval));
          if (e.ffval) check("first_fail_vec", int'(ffv_a), e.ffv);
          check("pass", int'(pass_a), int'(e.pass));
          check("busy_at_done", int'(busy_a), 0);
          check("vec_last", int'(vec_a), 7);
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
          check("resp_log", int'(log_a), int'(e.log));
`endif
        end
      end
      dq = done_a;
    end
  end

  task automatic wait_done_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    if (!seen) sb.delete();
  endtask

  task automatic run_a(input logic [7:0] resp, input bit extra_starts);
    tbl_a = resp;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    k_cur   = cyc;
    sb.push_back(model(resp, cyc));
    check("busy_on_accept", int'(busy_a), 1);
    check("done_cleared", int'(done_a), 0);
    if (extra_starts) begin
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (5) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done_a(40);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"}, int'(busy_a), 0);
    check({tag, "_done"}, int'(done_a), 0);
    check({tag, "_pass"}, int'(pass_a), 0);
    check({tag, "_err"}, int'(err_a), 0);
    check({tag, "_ffv"}, int'(ffv_a), 0);
    check({tag, "_ffval"}, int'(ffval_a), 0);
    check({tag, "_vec"}, int'(vec_a), 0);
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
    check({tag, "_log"}, int'(log_a), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         kb;
    bit         seen;
    logic [7:0] r;

    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_done", int'(done_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_a(EXP_A, 1'b0);              // correct XOR3
    run_a(EXP_A ^ 8'h20, 1'b0);      // vector 5 inverted
    run_a(8'h00, 1'b0);              // stuck-at-0
    run_a(EXP_A, 1'b1);              // starts while busy are ignored
    run_a(~EXP_A, 1'b0);             // every vector wrong: full count
    for (int t = 0; t < 4; t++) begin
      r = 8'($urandom);
      run_a(r, 1'b0);
    end

    // Asynchronous reset mid-sweep with partial errors recorded.
    tbl_a = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    k_cur   = cyc;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_a_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_a || busy_a) seen = 1'b1;
    end
    check("no_activity_after_rst", int'(seen), 0);

    run_a(EXP_A, 1'b0);              // recovers after reset

    // Instance B: SETTLE=3, majority gate against MAJ3.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    kb      = cyc;
    check("b_busy_on_accept", int'(busy_b), 1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
      else if (busy_b) check("b_vec_hold", int'(vec_b), (cyc - kb) / 4);
    end
    check("b_done_seen", int'(seen), 1);
    if (seen) begin
      check("b_done_cycle", cyc, kb + 8 * 4);
      check("b_pass", int'(pass_b), 1);
      check("b_err_count", int'(err_b), 0);
      check("b_first_fail_valid", int'(ffval_b), 0);
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
      check("b_resp_log", int'(log_b), int'(checker_pkg::MAJ3));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
